note_judge: RTL and testbench
=============================

Name: note_judge

Overview:
- Consumer end of the expected-note stream produced by the song note senders.
- Samples a 5-bit fret chord on every eighth-beat tick and delays it through a TRAVEL-slot scroll line, which drives the on-screen highway.
- Judges the player's strum and fret input against the chord at the hit line, emitting hit/miss pulses and maintaining combo, multiplier and score.

Parameters:
- LANES, 5, fret lanes per chord (bit 0 = green … bit 4 = orange).
- TRAVEL, 8, eighth-beat slots from note entry to the hit line (≥2).
- COMBO_STEP, 10, consecutive hits per multiplier step.
- MULT_MAX, 4, multiplier ceiling.

Ports:
- clk  in  1  system clock.
- resetn  in  1  asynchronous active-low reset.
- load  in  1  song playing; low = idle/flush.
- eight_beat  in  1  one-clk tick per eighth note, same tick that advances the note sender.
- exp_notes  in  LANES  expected chord from note sender; 0 = no note.
- frets  in  LANES  held fret buttons, already synchronised.
- strum  in  1  one-clk strum pulse, already debounced.
- hit  out  1  one-clk pulse, correct chord strummed.
- miss  out  1  one-clk pulse, wrong chord, overstrum or note passed unplayed.
- combo  out  8  consecutive-hit count.
- multiplier  out  3  current multiplier, 1..MULT_MAX.
- score  out  16  accumulated score.
- lane_view  out  TRAVEL*LANES  scroll line contents for VGA. Slot k occupies bits [k*LANES +: LANES]; slot TRAVEL-1 is the hit line.

Behaviour:
- Reset (resetn=0, async): all slots 0 with judged flags 0; hit=0, miss=0, combo=0, multiplier=1, score=0.
- Slot state: each slot holds a chord (LANES bits) plus a judged flag.
- Scroll, on a clk edge with load=1 and eight_beat=1:
  - slot0 <= exp_notes sampled that cycle, judged=0.
  - slot k <= slot k-1.
  - slot TRAVEL-1 leaves the line.
- Passed note: if the leaving slot is non-zero and unjudged, assert miss next cycle.
- Strum judgement (load=1, strum=1), evaluated on the hit slot as it stands before any same-cycle shift:
  - Hit slot non-zero, unjudged, frets == chord exactly → hit; mark slot judged.
  - Hit slot non-zero, unjudged, frets ≠ chord → miss; mark slot judged, so no second miss when it leaves.
  - Hit slot zero, or already judged → overstrum → miss; slot untouched.
- Simultaneous strum and eight_beat:
  - Judge first, then shift.
  - A hit or wrong judgement on the leaving slot suppresses its passed-note miss.
  - An overstrum plus an unjudged leaving note produces one miss pulse, not two.
- hit and miss are mutually exclusive, registered, and high for exactly one cycle, one clk after the triggering edge.
- Combo, updated in the same cycle as the pulse:
  - On hit: combo +1, saturating at 255.
  - On miss: combo 0.
- Multiplier: min(1 + combo/COMBO_STEP, MULT_MAX), registered and updated together with combo.
  - combo 0–9 → 1; 10–19 → 2; 20–29 → 3; ≥30 → 4.
- Score: on hit, score += multiplier value before this hit's combo increment. Saturates at 16'hFFFF, no wrap.
- load=0:
  - Synchronously flush all slots and judged flags.
  - combo=0, multiplier=1, no pulses; eight_beat and strum are ignored.
  - score holds, so the end-of-song total stays displayed.
  - load returning to 1 starts from an empty line.
- Reset mid-song: everything returns to reset values immediately, including score.
- lane_view is driven directly from the slot registers, so it reflects a shift in the cycle after the tick. Judged slots still display their chord.

Decomposition:
- Shared package gh_pkg holds:
  - LANES;
  - NOTE_NONE = 0;
  - chord constants CHORD_A5 = 5'b00111 and CHORD_G5 = 5'b01011;
  - COMBO_STEP, MULT_MAX, SCORE_MAX;
  - a slot struct {chord, judged} for reuse by the VGA renderer.
- One sub-module, note_scroll_line: the TRAVEL-deep slot shift register with a judge-mark input and a leaving-slot output. note_judge keeps the judgement logic and the combo/score counters.

Test Plan:
- Push 5'b00111 at tick 0, then zeros; at tick 7 with frets=00111, strum one cycle after the tick → hit=1 next cycle, combo=1, score=1, no miss at tick 8.
- Same chord, strum with frets=01011 → miss=1, combo=0; no additional miss when the slot leaves at tick 8.
- Chord never played → exactly one miss, the cycle after tick 8; combo cleared from 5 to 0.
- 31 consecutive correct hits → multiplier steps 1→2 at combo 10, →3 at 20, →4 at 30; score = 10·1 + 10·2 + 10·3 + 4 = 64.
- Strum on an empty hit slot → miss; strum and eight_beat in the same cycle with the correct chord leaving → single hit, no miss.
- load dropped mid-song with score=40 → lane_view=0 and combo=0 next cycle, score stays 40. resetn pulsed low asynchronously → score=0 without a clock edge.

Source files
------------

// File: rtl/gh_pkg.sv
// Shared note-highway types and constants, used by the hit judge and the VGA renderer.
// A slot carries a chord plus a flag recording whether the player has already been judged on it.
package gh_pkg;

    localparam int LANES      = 5;
    localparam int COMBO_STEP = 10;
    localparam int MULT_MAX   = 4;

    localparam int COMBO_W = 8;
    localparam int MULT_W  = 3;
    localparam int SCORE_W = 16;

    typedef logic [LANES-1:0] chord_t;

    localparam chord_t NOTE_NONE = '0;
    localparam chord_t CHORD_A5  = 5'b00111;
    localparam chord_t CHORD_G5  = 5'b01011;

    localparam logic [COMBO_W-1:0] COMBO_MAX = '1;
    localparam logic [SCORE_W-1:0] SCORE_MAX = 16'hFFFF;

    typedef struct packed {
        chord_t chord;
        logic   judged;
    } slot_t;

    // Multiplier earned by a given combo: one step per COMBO_STEP hits, capped at MULT_MAX.
    function automatic logic [MULT_W-1:0] mult_of(input logic [COMBO_W-1:0] combo);
        int steps;
        steps = int'(combo) / COMBO_STEP;
        if (steps >= MULT_MAX - 1) begin
            return MULT_W'(MULT_MAX);
        end
        return MULT_W'(steps + 1);
    endfunction

endpackage

// File: rtl/note_scroll_line.sv
// TRAVEL-deep scroll line of note slots; slot TRAVEL-1 is the hit line and the slot that leaves.
// A shift takes priority over a judge mark, because a marked slot that shifts out is gone anyway.
module note_scroll_line
    import gh_pkg::*;
#(
    parameter int TRAVEL = 8
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic                    i_flush,
    input  logic                    i_shift,
    input  chord_t                  i_chord,
    input  logic                    i_mark,
    output slot_t                   o_leave_slot,
    output logic [TRAVEL*LANES-1:0] o_lane_view
);

    slot_t [TRAVEL-1:0] r_slots;
    slot_t              w_entry;

    assign w_entry = '{chord: i_chord, judged: 1'b0};

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            // NOTE: the slot array is reset like any other register, since the highway must show empty after reset.
            r_slots <= '0;
        end else if (i_flush) begin
            r_slots <= '0;
        end else if (i_shift) begin
            // NOTE: non-blocking assignment, so every slot takes its neighbour's pre-edge value.
            r_slots <= {r_slots[TRAVEL-2:0], w_entry};
        end else if (i_mark) begin
            r_slots[TRAVEL-1].judged <= 1'b1;
        end
    end

    assign o_leave_slot = r_slots[TRAVEL-1];

    for (genvar k = 0; k < TRAVEL; k++) begin : g_view
        assign o_lane_view[k*LANES +: LANES] = r_slots[k].chord;
    end

endmodule

// File: rtl/note_judge.sv
// Judges strums against the chord on the hit line and keeps combo, multiplier and score.
// The judgement is made on the hit slot before any shift in the same cycle, so a leaving note judged now never also counts as passed.
module note_judge
    import gh_pkg::*;
#(
    parameter int TRAVEL = 8
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic                    load,
    input  logic                    eight_beat,
    input  logic [LANES-1:0]        exp_notes,
    input  logic [LANES-1:0]        frets,
    input  logic                    strum,
    output logic                    hit,
    output logic                    miss,
    output logic [COMBO_W-1:0]      combo,
    output logic [MULT_W-1:0]       multiplier,
    output logic [SCORE_W-1:0]      score,
    output logic [TRAVEL*LANES-1:0] lane_view
);

    localparam int SUM_W = SCORE_W + 1;

    slot_t              w_hit_slot;
    logic               w_strum;
    logic               w_tick;
    logic               w_live;
    logic               w_mark;
    logic               w_hit;
    logic               w_miss;
    logic [COMBO_W-1:0] w_combo_nxt;
    logic [SCORE_W-1:0] w_score_nxt;
    logic [SUM_W-1:0]   w_score_sum;

    logic               r_hit;
    logic               r_miss;
    logic [COMBO_W-1:0] r_combo;
    logic [MULT_W-1:0]  r_mult;
    logic [SCORE_W-1:0] r_score;

    note_scroll_line #(
        .TRAVEL (TRAVEL)
    ) u_scroll (
        .clk          (clk),
        .resetn       (resetn),
        .i_flush      (!load),
        .i_shift      (w_tick),
        .i_chord      (exp_notes),
        .i_mark       (w_mark),
        .o_leave_slot (w_hit_slot),
        .o_lane_view  (lane_view)
    );

    // A strum on a live note always judges it; a strum on nothing live is an overstrum.
    always_comb begin
        w_strum = load && strum;
        w_tick  = load && eight_beat;
        w_live  = (w_hit_slot.chord != NOTE_NONE) && !w_hit_slot.judged;
        w_mark  = w_strum && w_live;
        w_hit   = w_mark && (frets == w_hit_slot.chord);
        w_miss  = (w_mark && !w_hit)
               || (w_strum && !w_live)
               || (w_tick && w_live && !w_strum);
    end

    always_comb begin
        // NOTE: defaults first, so every path assigns every output and no latch is inferred.
        w_combo_nxt = r_combo;
        w_score_nxt = r_score;
        w_score_sum = {1'b0, r_score} + SUM_W'(r_mult);
        if (!load || w_miss) begin
            w_combo_nxt = '0;
        end else if (w_hit) begin
            if (r_combo != COMBO_MAX) begin
                w_combo_nxt = r_combo + 1'b1;
            end
            w_score_nxt = w_score_sum[SCORE_W] ? SCORE_MAX : w_score_sum[SCORE_W-1:0];
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_hit   <= 1'b0;
            r_miss  <= 1'b0;
            r_combo <= '0;
            r_mult  <= MULT_W'(1);
            r_score <= '0;
        end else begin
            r_hit   <= w_hit;
            r_miss  <= w_miss;
            r_combo <= w_combo_nxt;
            r_mult  <= mult_of(w_combo_nxt);
            r_score <= w_score_nxt;
        end
    end

    assign hit        = r_hit;
    assign miss       = r_miss;
    assign combo      = r_combo;
    assign multiplier = r_mult;
    assign score      = r_score;

endmodule

// File: tb/tb_note_judge.sv
// Self-checking bench for note_judge: a slot-list model checked every cycle, plus literal checkpoints.
module tb_note_judge;
    import gh_pkg::*;

    localparam int TRAVEL = 8;
    localparam int LV_W   = TRAVEL * LANES;

    logic             clk        = 1'b0;
    logic             resetn     = 1'b0;
    logic             load       = 1'b0;
    logic             eight_beat = 1'b0;
    logic             strum      = 1'b0;
    chord_t           exp_notes  = '0;
    chord_t           frets      = '0;
    logic             hit;
    logic             miss;
    logic [7:0]       combo;
    logic [2:0]       multiplier;
    logic [15:0]      score;
    logic [LV_W-1:0]  lane_view;

    note_judge #(.TRAVEL(TRAVEL)) dut (
        .clk        (clk),
        .resetn     (resetn),
        .load       (load),
        .eight_beat (eight_beat),
        .exp_notes  (exp_notes),
        .frets      (frets),
        .strum      (strum),
        .hit        (hit),
        .miss       (miss),
        .combo      (combo),
        .multiplier (multiplier),
        .score      (score),
        .lane_view  (lane_view)
    );

    always #5 clk = ~clk;

    int n_checks   = 0;
    int n_pass     = 0;
    int dut_hits   = 0;
    int dut_misses = 0;
    int base_hits;
    int base_misses;
    bit chk_en     = 1'b0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, got, exp, $time);
    endtask

    // ---------------- behavioural model ----------------
    chord_t m_chord  [TRAVEL];
    bit     m_judged [TRAVEL];
    int     m_combo = 0;
    int     m_score = 0;
    bit     m_hit   = 1'b0;
    bit     m_miss  = 1'b0;

    function automatic int mult_ref(input int c);
        int m;
        m = 1 + c / 10;
        return (m > 4) ? 4 : m;
    endfunction

    function automatic logic [LV_W-1:0] model_view();
        logic [LV_W-1:0] v;
        v = '0;
        for (int k = 0; k < TRAVEL; k++) v[k*LANES +: LANES] = m_chord[k];
        return v;
    endfunction

    task automatic model_clear_line();
        for (int k = 0; k < TRAVEL; k++) begin
            m_chord[k]  = '0;
            m_judged[k] = 1'b0;
        end
    endtask

    initial begin
        model_clear_line();
        forever begin
            @(posedge clk or negedge resetn);
            m_hit  = 1'b0;
            m_miss = 1'b0;
            if (!resetn) begin
                model_clear_line();
                m_combo = 0;
                m_score = 0;
            end else if (!load) begin
                model_clear_line();
                m_combo = 0;
            end else begin
                if (strum) begin
                    if (m_chord[TRAVEL-1] != '0 && !m_judged[TRAVEL-1]) begin
                        if (frets == m_chord[TRAVEL-1]) m_hit = 1'b1;
                        else m_miss = 1'b1;
                        m_judged[TRAVEL-1] = 1'b1;
                    end else begin
                        m_miss = 1'b1;
                    end
                end
                if (eight_beat) begin
                    if (m_chord[TRAVEL-1] != '0 && !m_judged[TRAVEL-1]) m_miss = 1'b1;
                    for (int k = TRAVEL - 1; k > 0; k--) begin
                        m_chord[k]  = m_chord[k-1];
                        m_judged[k] = m_judged[k-1];
                    end
                    m_chord[0]  = exp_notes;
                    m_judged[0] = 1'b0;
                end
                if (m_hit) begin
                    m_score = m_score + mult_ref(m_combo);
                    if (m_score > 65535) m_score = 65535;
                    m_combo = (m_combo < 255) ? m_combo + 1 : 255;
                end else if (m_miss) begin
                    m_combo = 0;
                end
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    initial begin
        forever begin
            @(negedge clk);
            if (hit) dut_hits++;
            if (miss) dut_misses++;
            if (chk_en) begin
                check("hit", 64'(hit), 64'(m_hit));
                check("miss", 64'(miss), 64'(m_miss));
                check("combo", 64'(combo), 64'(m_combo));
                check("multiplier", 64'(multiplier), 64'(mult_ref(m_combo)));
                check("score", 64'(score), 64'(m_score));
                check("lane_view", 64'(lane_view), 64'(model_view()));
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick_cycle(input chord_t note_in, input bit do_strum, input chord_t fr, input bit same_cycle);
        @(negedge clk);
        eight_beat = 1'b1;
        exp_notes  = note_in;
        frets      = fr;
        strum      = do_strum && same_cycle;
        @(negedge clk);
        eight_beat = 1'b0;
        exp_notes  = '0;
        strum      = do_strum && !same_cycle;
        @(negedge clk);
        strum      = 1'b0;
        @(negedge clk);
    endtask

    task automatic idle_ticks(input int n);
        for (int i = 0; i < n; i++) tick_cycle(NOTE_NONE, 1'b0, '0, 1'b0);
    endtask

    // Push n copies of ch, then strum each as it reaches the hit line.
    task automatic play_run(input int n, input chord_t ch, input int wrong_at, input int skip_at);
        for (int t = 0; t < n + TRAVEL - 1; t++) begin
            int idx;
            idx = t - (TRAVEL - 1);
            tick_cycle((t < n) ? ch : NOTE_NONE, (idx >= 0) && (idx != skip_at),
                       (idx == wrong_at) ? CHORD_G5 : ch, 1'b0);
        end
    endtask

    task automatic mark_counts();
        base_hits   = dut_hits;
        base_misses = dut_misses;
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        resetn = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(negedge clk);
        #1;
        check("reset_hit", 64'(hit), 64'd0);
        check("reset_miss", 64'(miss), 64'd0);
        check("reset_combo", 64'(combo), 64'd0);
        check("reset_mult", 64'(multiplier), 64'd1);
        check("reset_score", 64'(score), 64'd0);
        check("reset_lane_view", 64'(lane_view), 64'd0);
        @(negedge clk);
        resetn = 1'b1;
        load   = 1'b1;
        chk_en = 1'b1;

        // Single correct hit at tick 7; leaving at tick 8 gives no miss.
        mark_counts();
        play_run(1, CHORD_A5, -1, -1);
        idle_ticks(1);
        #1;
        check("t1_hits", 64'(dut_hits - base_hits), 64'd1);
        check("t1_misses", 64'(dut_misses - base_misses), 64'd0);
        check("t1_combo", 64'(combo), 64'd1);
        check("t1_score", 64'(score), 64'd1);

        // Wrong frets: one miss, none extra when it leaves.
        mark_counts();
        play_run(1, CHORD_A5, 0, -1);
        idle_ticks(2);
        #1;
        check("t2_hits", 64'(dut_hits - base_hits), 64'd0);
        check("t2_misses", 64'(dut_misses - base_misses), 64'd1);
        check("t2_combo", 64'(combo), 64'd0);

        // Combo 5, then an unplayed note clears it with one miss.
        play_run(5, CHORD_A5, -1, -1);
        #1;
        check("t3_combo5", 64'(combo), 64'd5);
        check("t3_score", 64'(score), 64'd6);
        mark_counts();
        play_run(1, CHORD_A5, -1, 0);
        idle_ticks(1);
        #1;
        check("t3_misses", 64'(dut_misses - base_misses), 64'd1);
        check("t3_combo0", 64'(combo), 64'd0);

        // 31 hits from reset walk the multiplier 1..4.
        pulse_reset();
        mark_counts();
        play_run(31, CHORD_A5, -1, -1);
        #1;
        check("t4_hits", 64'(dut_hits - base_hits), 64'd31);
        check("t4_combo", 64'(combo), 64'd31);
        check("t4_mult", 64'(multiplier), 64'd4);
        check("t4_score", 64'(score), 64'd64);

        // Overstrum on an empty line.
        idle_ticks(1);
        mark_counts();
        tick_cycle(NOTE_NONE, 1'b1, CHORD_A5, 1'b0);
        #1;
        check("t5_overstrum_miss", 64'(dut_misses - base_misses), 64'd1);
        check("t5_combo", 64'(combo), 64'd0);

        // Strum on the tick that moves the note off the line.
        tick_cycle(CHORD_A5, 1'b0, '0, 1'b0);
        idle_ticks(TRAVEL - 1);
        mark_counts();
        tick_cycle(NOTE_NONE, 1'b1, CHORD_A5, 1'b1);
        idle_ticks(1);
        #1;
        check("t5_same_hits", 64'(dut_hits - base_hits), 64'd1);
        check("t5_same_misses", 64'(dut_misses - base_misses), 64'd0);
        tick_cycle(CHORD_G5, 1'b0, '0, 1'b0);
        idle_ticks(TRAVEL - 1);
        mark_counts();
        tick_cycle(NOTE_NONE, 1'b1, CHORD_A5, 1'b1);
        idle_ticks(1);
        #1;
        check("t5_same_wrong_misses", 64'(dut_misses - base_misses), 64'd1);

        // Build score 40, then drop load with notes in flight.
        pulse_reset();
        play_run(15, CHORD_A5, -1, -1);
        play_run(1, CHORD_A5, 0, -1);
        play_run(15, CHORD_A5, -1, -1);
        #1;
        check("t6_score40", 64'(score), 64'd40);
        repeat (3) tick_cycle(CHORD_A5, 1'b0, '0, 1'b0);
        #1;
        check("t6_line_busy", 64'(lane_view != '0), 64'd1);
        @(negedge clk);
        load       = 1'b0;
        eight_beat = 1'b1;
        strum      = 1'b1;
        exp_notes  = CHORD_A5;
        @(negedge clk);
        #1;
        check("t6_flush_view", 64'(lane_view), 64'd0);
        check("t6_flush_combo", 64'(combo), 64'd0);
        check("t6_flush_mult", 64'(multiplier), 64'd1);
        check("t6_hold_score", 64'(score), 64'd40);
        check("t6_no_miss", 64'(miss), 64'd0);
        @(negedge clk);
        eight_beat = 1'b0;
        strum      = 1'b0;
        exp_notes  = '0;
        load       = 1'b1;
        play_run(2, CHORD_G5, -1, -1);
        #1;
        check("t6_score42", 64'(score), 64'd42);

        // Asynchronous reset between clock edges.
        @(negedge clk);
        #2;
        resetn = 1'b0;
        #1;
        check("t7_async_score", 64'(score), 64'd0);
        check("t7_async_view", 64'(lane_view), 64'd0);
        check("t7_async_mult", 64'(multiplier), 64'd1);
        @(negedge clk);
        resetn = 1'b1;
        idle_ticks(1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
